// File: rtl/pwm_ramp_sequencer.sv
// Single-channel PWM with a soft-start / hold / soft-stop duty sequencer.
// One shared timer paces both the duty steps and the hold interval.
module pwm_ramp_sequencer #(
  parameter int PWM_BITS    = 8,
  parameter int MAX_DUTY    = 255,
  parameter int STEP_DIV    = 1_000_000,
  parameter int HOLD_CYCLES = 300_000_000
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                start,
  input  logic                abort,
  output logic [PWM_BITS-1:0] duty,
  output logic                pwm_out,
  output logic                busy,
  output logic                done,
  output logic [1:0]          state
);

  localparam int TMAX = (STEP_DIV > HOLD_CYCLES) ? STEP_DIV : HOLD_CYCLES;
  localparam int TW   = (TMAX > 1) ? $clog2(TMAX) : 1;

  localparam logic [TW-1:0]       STEP_LAST = TW'(STEP_DIV - 1);
  localparam logic [TW-1:0]       HOLD_LAST = TW'(HOLD_CYCLES - 1);
  localparam logic [PWM_BITS-1:0] DUTY_MAX  = PWM_BITS'(MAX_DUTY);
  localparam logic [PWM_BITS-1:0] DUTY_ONE  = PWM_BITS'(1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_UP   = 2'd1,
    S_HOLD = 2'd2,
    S_DOWN = 2'd3
  } state_t;

  state_t              r_state;
  logic [PWM_BITS-1:0] r_duty;
  logic [TW-1:0]       r_tcnt;
  logic                r_done;
  logic [PWM_BITS-1:0] r_pcnt;
  logic                r_pwm;

  state_t              w_state_next;
  logic [PWM_BITS-1:0] w_duty_next;
  logic [TW-1:0]       w_tcnt_next;
  logic                w_done_next;
  logic                w_step;
  logic                w_hold_end;

  assign w_step     = (r_tcnt == STEP_LAST);
  assign w_hold_end = (r_tcnt == HOLD_LAST);

  always_comb begin
    w_state_next = r_state;
    w_duty_next  = r_duty;
    w_tcnt_next  = r_tcnt + 1'b1;
    w_done_next  = 1'b0;
    case (r_state)
      S_IDLE: begin
        w_tcnt_next = '0;
        if (start) begin
          w_state_next = S_UP;
        end
      end
      S_UP: begin
        if (w_step) begin
          w_tcnt_next = '0;
          // A retrigger can re-enter the ramp already at the ceiling; never step past it.
          if (r_duty >= DUTY_MAX) begin
            w_state_next = S_HOLD;
          end else begin
            w_duty_next = r_duty + 1'b1;
            if (w_duty_next == DUTY_MAX) begin
              w_state_next = S_HOLD;
            end
          end
        end
        // Abort overrides the destination but a coincident step still lands.
        if (abort) begin
          w_state_next = S_DOWN;
          w_tcnt_next  = '0;
        end
      end
      S_HOLD: begin
        if (abort) begin
          w_state_next = S_DOWN;
          w_tcnt_next  = '0;
        end else if (start) begin
          w_tcnt_next = '0;
        end else if (w_hold_end) begin
          w_state_next = S_DOWN;
          w_tcnt_next  = '0;
        end
      end
      S_DOWN: begin
        if (start) begin
          w_state_next = S_UP;
          w_tcnt_next  = '0;
        end else if (w_step) begin
          w_tcnt_next = '0;
          if (r_duty <= DUTY_ONE) begin
            w_duty_next  = '0;
            w_state_next = S_IDLE;
            w_done_next  = 1'b1;
          end else begin
            w_duty_next = r_duty - 1'b1;
          end
        end
      end
      default: begin
        w_state_next = S_IDLE;
        w_duty_next  = '0;
        w_tcnt_next  = '0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_duty  <= '0;
      r_tcnt  <= '0;
      r_done  <= 1'b0;
    end else begin
      r_state <= w_state_next;
      r_duty  <= w_duty_next;
      r_tcnt  <= w_tcnt_next;
      r_done  <= w_done_next;
    end
  end

  // PWM compares against the registered duty, so pwm_out trails duty by one cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_pcnt <= '0;
      r_pwm  <= 1'b0;
    end else begin
      r_pcnt <= r_pcnt + 1'b1;
      r_pwm  <= (r_pcnt < r_duty);
    end
  end

  assign duty    = r_duty;
  assign pwm_out = r_pwm;
  assign busy    = (r_state != S_IDLE);
  assign done    = r_done;
  assign state   = r_state;

endmodule

// File: tb/tb_pwm_ramp_sequencer.sv
// Directed bench for pwm_ramp_sequencer with small parameters
// (PWM_BITS=4, MAX_DUTY=15, STEP_DIV=4, HOLD_CYCLES=10).
module tb_pwm_ramp_sequencer;

  logic       clk = 1'b0;
  logic       rst;
  logic       start;
  logic       abort;
  logic [3:0] duty;
  logic       pwm_out;
  logic       busy;
  logic       done;
  logic [1:0] state;

  int errors   = 0;
  int checks   = 0;
  int done_cnt = 0;
  int d0;
  int highs;

  pwm_ramp_sequencer #(
    .PWM_BITS(4), .MAX_DUTY(15), .STEP_DIV(4), .HOLD_CYCLES(10)
  ) dut (
    .clk(clk), .rst(rst), .start(start), .abort(abort),
    .duty(duty), .pwm_out(pwm_out), .busy(busy), .done(done), .state(state)
  );

  always #5 clk = ~clk;

  always @(negedge clk) if (done === 1'b1) done_cnt++;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, got, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic wait_state(input logic [1:0] s, input int limit, input string tag);
    int n = 0;
    while (state !== s && n < limit) begin tick(1); n++; end
    chk(tag, state, s);
  endtask

  task automatic wait_duty(input logic [3:0] v, input int limit, input string tag);
    int n = 0;
    while (duty !== v && n < limit) begin tick(1); n++; end
    chk(tag, duty, v);
  endtask

  task automatic count_high(input int n, output int c);
    c = 0;
    repeat (n) begin tick(1); if (pwm_out === 1'b1) c++; end
  endtask

  initial begin
    rst = 1'b1; start = 1'b1; abort = 1'b0;

    // Reset held with start asserted
    for (int i = 0; i < 3; i++) begin
      tick(1);
      chk("rst_state", state, 0);
      chk("rst_duty", duty, 0);
      chk("rst_pwm", pwm_out, 0);
      chk("rst_busy", busy, 0);
      chk("rst_done", done, 0);
    end
    rst = 1'b0;
    tick(1);                                   // edge 0 of the full cycle
    chk("rel_state", state, 1);
    chk("rel_busy", busy, 1);
    start = 1'b0;
    d0 = done_cnt;

    // Full cycle
    tick(3);  chk("fc_e3_duty", duty, 0);
    tick(1);  chk("fc_e4_duty", duty, 1);
    tick(55); chk("fc_e59_duty", duty, 14); chk("fc_e59_state", state, 1);
    tick(1);  chk("fc_e60_duty", duty, 15); chk("fc_e60_state", state, 2);
    tick(9);  chk("fc_e69_state", state, 2);
    tick(1);  chk("fc_e70_state", state, 3); chk("fc_e70_duty", duty, 15);
    tick(59); chk("fc_e129_duty", duty, 1); chk("fc_e129_done", done, 0);
    tick(1);  chk("fc_e130_duty", duty, 0); chk("fc_e130_state", state, 0);
    chk("fc_e130_done", done, 1); chk("fc_e130_busy", busy, 0);
    tick(1);  chk("fc_e131_done", done, 0);
    chk("fc_done_count", done_cnt - d0, 1);

    // Idle: PWM silent, abort ignored
    count_high(32, highs); chk("idle_pwm_high", highs, 0);
    abort = 1'b1; tick(2); chk("idle_abort_state", state, 0); abort = 1'b0;

    // Abort in HOLD
    d0 = done_cnt;
    start = 1'b1; tick(1); start = 1'b0;       // edge 0
    tick(62); chk("ab_e62_state", state, 2);
    abort = 1'b1; tick(1); abort = 1'b0;       // edge 63
    chk("ab_e63_state", state, 3); chk("ab_e63_duty", duty, 15);
    tick(4);  chk("ab_e67_duty", duty, 14);
    tick(55); chk("ab_e122_duty", duty, 1); chk("ab_e122_state", state, 3);
    tick(1);  chk("ab_e123_state", state, 0); chk("ab_e123_done", done, 1);
    tick(1);  chk("ab_done_count", done_cnt - d0, 1);

    // Abort coinciding with the final up-step
    start = 1'b1; tick(1); start = 1'b0;
    tick(59); chk("abf_e59_duty", duty, 14);
    abort = 1'b1; tick(1); abort = 1'b0;
    chk("abf_e60_duty", duty, 15); chk("abf_e60_state", state, 3);
    wait_state(2'd0, 100, "abf_idle");
    tick(1);

    // Hold extension, PWM at full duty, retrigger in RAMP_DOWN
    start = 1'b1; tick(1); start = 1'b0;
    tick(62); chk("rt_e62_state", state, 2);
    start = 1'b1; tick(20); chk("rt_hold_held", state, 2);
    count_high(16, highs); chk("rt_pwm_15of16", highs, 15);
    chk("rt_hold_after_pwm", state, 2);
    start = 1'b0;
    wait_state(2'd3, 30, "rt_down");
    d0 = done_cnt;
    wait_duty(4'd7, 100, "rt_duty7");
    start = 1'b1; tick(1); start = 1'b0;
    chk("rt_up_state", state, 1); chk("rt_up_duty", duty, 7);
    tick(3); chk("rt_up_duty_hold", duty, 7);
    tick(1); chk("rt_up_duty8", duty, 8);
    chk("rt_no_done", done_cnt - d0, 0);
    abort = 1'b1; tick(1); abort = 1'b0;
    chk("rt_abort_state", state, 3);
    wait_state(2'd0, 100, "rt_idle");
    tick(1);

    // Reset mid-ramp
    start = 1'b1; tick(1); start = 1'b0;
    wait_duty(4'd9, 100, "mr_duty9");
    chk("mr_state_up", state, 1);
    d0 = done_cnt;
    rst = 1'b1; tick(1); rst = 1'b0;
    chk("mr_duty", duty, 0); chk("mr_state", state, 0);
    chk("mr_busy", busy, 0); chk("mr_done", done, 0);
    tick(2); chk("mr_state_after", state, 0);
    chk("mr_no_done", done_cnt - d0, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
